// File: rtl/pipe_idex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush squash, external hold, and saturating stall/hold counters.
module pipe_idex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IFID_Valid,
  input  logic [4:0]        IFID_RegisterRs,
  input  logic [4:0]        IFID_RegisterRt,
  input  logic [4:0]        IFID_RegisterRd,
  input  logic              IFID_UsesRt,
  input  logic [DATA_W-1:0] IFID_ReadData1,
  input  logic [DATA_W-1:0] IFID_ReadData2,
  input  logic [DATA_W-1:0] IFID_Imm,
  input  logic [8:0]        IFID_Ctrl,
  input  logic              flush,
  input  logic              hold,
  output logic              IDEX_Valid,
  output logic [4:0]        IDEX_RegisterRs,
  output logic [4:0]        IDEX_RegisterRt,
  output logic [4:0]        IDEX_RegisterRd,
  output logic [DATA_W-1:0] IDEX_ReadData1,
  output logic [DATA_W-1:0] IDEX_ReadData2,
  output logic [DATA_W-1:0] IDEX_Imm,
  output logic [8:0]        IDEX_Ctrl,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  hold_count
);

  // Ctrl packing: {RegDst,ALUSrc,ALUOp[1:0],MemRead,MemWrite,MemtoReg,RegWrite,Branch}
  localparam int unsigned MEMREAD_BIT = 4;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic rsMatch;
  logic rtMatch;

  // Load-use hazard: a valid load in EX writing a register the ID instruction reads
  always_comb begin
    rsMatch        = (IDEX_RegisterRt == IFID_RegisterRs);
    rtMatch        = IFID_UsesRt & (IDEX_RegisterRt == IFID_RegisterRt);
    load_use_stall = IDEX_Valid & IDEX_Ctrl[MEMREAD_BIT] & (IDEX_RegisterRt != 5'd0) &
                     IFID_Valid & (rsMatch | rtMatch);
  end

  // Upstream write enables: hold freezes, flush overrides the hazard, reset behaves as normal
  always_comb begin
    PCWrite   = reset | (~hold & (flush | ~load_use_stall));
    IFIDWrite = PCWrite;
  end

  // Pipeline register update with reset > hold > flush > stall > capture priority
  always_ff @(posedge clk) begin
    if (reset) begin
      IDEX_Valid      <= 1'b0;
      IDEX_RegisterRs <= '0;
      IDEX_RegisterRt <= '0;
      IDEX_RegisterRd <= '0;
      IDEX_ReadData1  <= '0;
      IDEX_ReadData2  <= '0;
      IDEX_Imm        <= '0;
      IDEX_Ctrl       <= '0;
      stall_count     <= '0;
      hold_count      <= '0;
    end else if (hold) begin
      if (hold_count != '1) begin
        hold_count <= hold_count + CNT_ONE;
      end
    end else if (flush || load_use_stall) begin
      // Bubble: only Valid/Ctrl matter, operand fields cleared so forwarding sees $0
      IDEX_Valid      <= 1'b0;
      IDEX_RegisterRs <= '0;
      IDEX_RegisterRt <= '0;
      IDEX_RegisterRd <= '0;
      IDEX_ReadData1  <= '0;
      IDEX_ReadData2  <= '0;
      IDEX_Imm        <= '0;
      IDEX_Ctrl       <= '0;
      if (!flush && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_ONE;
      end
    end else begin
      IDEX_Valid      <= IFID_Valid;
      IDEX_RegisterRs <= IFID_RegisterRs;
      IDEX_RegisterRt <= IFID_RegisterRt;
      IDEX_RegisterRd <= IFID_RegisterRd;
      IDEX_ReadData1  <= IFID_ReadData1;
      IDEX_ReadData2  <= IFID_ReadData2;
      IDEX_Imm        <= IFID_Imm;
      IDEX_Ctrl       <= IFID_Ctrl;
    end
  end

endmodule

// File: tb/tb_pipe_idex_stage.sv
// Testbench for pipe_idex_stage: vector table with hand-derived hazard and
// write-enable expectations, plus a scoreboard queue for registered outputs.
module tb_pipe_idex_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;

  localparam logic [8:0] LW   = 9'b010010110;
  localparam logic [8:0] ADD  = 9'b101000010;
  localparam logic [8:0] SW   = 9'b010001000;
  localparam logic [8:0] ADDI = 9'b010000010;

  logic          clk;
  logic          reset;
  logic          IFID_Valid;
  logic [4:0]    IFID_RegisterRs, IFID_RegisterRt, IFID_RegisterRd;
  logic          IFID_UsesRt;
  logic [DW-1:0] IFID_ReadData1, IFID_ReadData2, IFID_Imm;
  logic [8:0]    IFID_Ctrl;
  logic          flush, hold;
  logic          IDEX_Valid;
  logic [4:0]    IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterRd;
  logic [DW-1:0] IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm;
  logic [8:0]    IDEX_Ctrl;
  logic          PCWrite, IFIDWrite, load_use_stall;
  logic [CW-1:0] stall_count, hold_count;

  pipe_idex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .IFID_Valid(IFID_Valid), .IFID_RegisterRs(IFID_RegisterRs),
    .IFID_RegisterRt(IFID_RegisterRt), .IFID_RegisterRd(IFID_RegisterRd),
    .IFID_UsesRt(IFID_UsesRt), .IFID_ReadData1(IFID_ReadData1),
    .IFID_ReadData2(IFID_ReadData2), .IFID_Imm(IFID_Imm), .IFID_Ctrl(IFID_Ctrl),
    .flush(flush), .hold(hold),
    .IDEX_Valid(IDEX_Valid), .IDEX_RegisterRs(IDEX_RegisterRs),
    .IDEX_RegisterRt(IDEX_RegisterRt), .IDEX_RegisterRd(IDEX_RegisterRd),
    .IDEX_ReadData1(IDEX_ReadData1), .IDEX_ReadData2(IDEX_ReadData2),
    .IDEX_Imm(IDEX_Imm), .IDEX_Ctrl(IDEX_Ctrl),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .load_use_stall(load_use_stall),
    .stall_count(stall_count), .hold_count(hold_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, hld, fl, valid;
    logic [4:0] rs, rt, rd;
    logic       usesRt;
    logic [8:0] ctrl;
    logic       chk;      // compare combinational outputs on this row
    logic       expStall;
    logic       expPcw;
  } vec_t;

  typedef struct {
    int            row;
    logic          valid;
    logic          known;  // operand fields defined (not a bubble)
    logic [4:0]    rs, rt, rd;
    logic [DW-1:0] d1, d2, imm;
    logic [8:0]    ctrl;
    logic [CW-1:0] sc, hc;
  } exp_t;

  vec_t vecs[35];
  exp_t sb[$];
  int   nCmp = 0;
  int   nFail = 0;

  function automatic vec_t mk(input logic rst, hld, fl, valid, input logic [4:0] rs, rt, rd,
                              input logic usesRt, input logic [8:0] ctrl,
                              input logic chk, expStall, expPcw);
    vec_t v;
    v.rst = rst; v.hld = hld; v.fl = fl; v.valid = valid;
    v.rs = rs; v.rt = rt; v.rd = rd; v.usesRt = usesRt; v.ctrl = ctrl;
    v.chk = chk; v.expStall = expStall; v.expPcw = expPcw;
    return v;
  endfunction

  task automatic check(input int row, input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
    end
  endtask

  // model state
  logic          mValid, mKnown;
  logic [4:0]    mRs, mRt, mRd;
  logic [DW-1:0] mD1, mD2, mImm;
  logic [8:0]    mCtrl;
  logic [CW-1:0] mSc, mHc;

  initial begin
    exp_t e;
    //           rst hld fl  v   rs  rt  rd  uRt ctrl  chk st  pcw
    vecs[0]  = mk(1, 0, 0, 1, 1, 5, 0, 0, LW,   0, 0, 1);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 9'd0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 1, 1, 5, 0, 0, LW,   1, 0, 1);  // lw $5
    vecs[3]  = mk(0, 0, 0, 1, 5, 7, 6, 1, ADD,  1, 1, 0);  // add $6,$5,$7 -> stall
    vecs[4]  = mk(0, 0, 0, 1, 5, 7, 6, 1, ADD,  1, 0, 1);  // held add enters
    vecs[5]  = mk(0, 0, 0, 1, 2, 5, 0, 0, LW,   1, 0, 1);
    vecs[6]  = mk(0, 0, 0, 1, 3, 5, 0, 1, SW,   1, 1, 0);  // sw uses Rt=5 -> stall
    vecs[7]  = mk(0, 0, 0, 1, 3, 5, 0, 1, SW,   1, 0, 1);
    vecs[8]  = mk(0, 0, 0, 1, 2, 5, 0, 0, LW,   1, 0, 1);
    vecs[9]  = mk(0, 0, 0, 1, 3, 5, 0, 0, ADDI, 1, 0, 1);  // addi Rt=5 not read
    vecs[10] = mk(0, 0, 0, 1, 1, 0, 0, 0, LW,   1, 0, 1);  // lw $0
    vecs[11] = mk(0, 0, 0, 1, 0, 0, 4, 1, ADD,  1, 0, 1);  // reads $0 -> no stall
    vecs[12] = mk(0, 0, 0, 1, 1, 5, 0, 0, LW,   1, 0, 1);
    vecs[13] = mk(0, 0, 1, 1, 5, 7, 6, 1, ADD,  1, 1, 1);  // flush over hazard
    vecs[14] = mk(0, 0, 0, 1, 1, 5, 0, 0, LW,   1, 0, 1);
    vecs[15] = mk(0, 1, 0, 1, 5, 7, 6, 1, ADD,  1, 1, 0);  // hold x3 with hazard
    vecs[16] = mk(0, 1, 0, 1, 5, 7, 6, 1, ADD,  1, 1, 0);
    vecs[17] = mk(0, 1, 0, 1, 5, 7, 6, 1, ADD,  1, 1, 0);
    vecs[18] = mk(0, 0, 0, 1, 5, 7, 6, 1, ADD,  1, 1, 0);  // release -> bubble
    vecs[19] = mk(0, 0, 0, 1, 5, 7, 6, 1, ADD,  1, 0, 1);
    vecs[20] = mk(0, 0, 0, 1, 1, 5, 0, 0, LW,   1, 0, 1);
    vecs[21] = mk(0, 0, 0, 1, 5, 7, 6, 1, ADD,  1, 1, 0);  // 4th bubble
    vecs[22] = mk(0, 0, 0, 1, 5, 7, 6, 1, ADD,  1, 0, 1);
    vecs[23] = mk(0, 0, 0, 1, 1, 5, 0, 0, LW,   1, 0, 1);
    vecs[24] = mk(0, 0, 0, 1, 5, 7, 6, 1, ADD,  1, 1, 0);  // 5th bubble
    vecs[25] = mk(0, 0, 0, 1, 5, 7, 6, 1, ADD,  1, 0, 1);
    vecs[26] = mk(0, 1, 0, 1, 5, 7, 6, 1, ADD,  1, 0, 0);  // 4th hold, saturated
    vecs[27] = mk(0, 0, 0, 1, 1, 5, 0, 0, LW,   1, 0, 1);
    vecs[28] = mk(1, 0, 0, 1, 5, 7, 6, 1, ADD,  0, 0, 1);  // reset mid-stall
    vecs[29] = mk(0, 0, 0, 1, 5, 7, 6, 1, ADD,  1, 0, 1);
    vecs[30] = mk(0, 0, 0, 0, 1, 5, 0, 0, LW,   1, 0, 1);  // invalid load
    vecs[31] = mk(0, 0, 0, 1, 5, 7, 6, 1, ADD,  1, 0, 1);  // no stall behind it
    vecs[32] = mk(0, 0, 0, 1, 1, 5, 0, 0, LW,   1, 0, 1);
    vecs[33] = mk(0, 0, 0, 0, 5, 7, 6, 1, ADD,  1, 0, 1);  // ID not valid
    vecs[34] = mk(0, 0, 0, 1, 5, 7, 6, 1, ADD,  1, 0, 1);

    {reset, hold, flush, IFID_Valid, IFID_UsesRt} = '0;
    {IFID_RegisterRs, IFID_RegisterRt, IFID_RegisterRd, IFID_Ctrl} = '0;
    {IFID_ReadData1, IFID_ReadData2, IFID_Imm} = '0;
    {mValid, mKnown, mRs, mRt, mRd, mD1, mD2, mImm, mCtrl, mSc, mHc} = '0;

    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; hold = vecs[i].hld; flush = vecs[i].fl;
      IFID_Valid = vecs[i].valid; IFID_RegisterRs = vecs[i].rs;
      IFID_RegisterRt = vecs[i].rt; IFID_RegisterRd = vecs[i].rd;
      IFID_UsesRt = vecs[i].usesRt; IFID_Ctrl = vecs[i].ctrl;
      IFID_ReadData1 = $urandom; IFID_ReadData2 = $urandom; IFID_Imm = $urandom;
      #1;
      if (vecs[i].chk) begin
        check(i, "load_use_stall", 32'(load_use_stall), 32'(vecs[i].expStall));
        check(i, "PCWrite", 32'(PCWrite), 32'(vecs[i].expPcw));
        check(i, "IFIDWrite", 32'(IFIDWrite), 32'(vecs[i].expPcw));
      end
      if (vecs[i].rst) begin
        {mValid, mRs, mRt, mRd, mD1, mD2, mImm, mCtrl, mSc, mHc} = '0;
        mKnown = 1'b1;
      end else if (vecs[i].hld) begin
        if (mHc != '1) mHc = mHc + 2'd1;
      end else if (vecs[i].fl || vecs[i].expStall) begin
        mValid = 1'b0; mCtrl = '0; mKnown = 1'b0;
        if (!vecs[i].fl && mSc != '1) mSc = mSc + 2'd1;
      end else begin
        mValid = vecs[i].valid; mRs = vecs[i].rs; mRt = vecs[i].rt; mRd = vecs[i].rd;
        mD1 = IFID_ReadData1; mD2 = IFID_ReadData2; mImm = IFID_Imm;
        mCtrl = vecs[i].ctrl; mKnown = 1'b1;
      end
      e.row = i; e.valid = mValid; e.known = mKnown; e.rs = mRs; e.rt = mRt; e.rd = mRd;
      e.d1 = mD1; e.d2 = mD2; e.imm = mImm; e.ctrl = mCtrl; e.sc = mSc; e.hc = mHc;
      sb.push_back(e);

      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        nCmp++; nFail++;
        $display("FAIL row %0d scoreboard: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        check(e.row, "IDEX_Valid", 32'(IDEX_Valid), 32'(e.valid));
        check(e.row, "IDEX_Ctrl", 32'(IDEX_Ctrl), 32'(e.ctrl));
        check(e.row, "stall_count", 32'(stall_count), 32'(e.sc));
        check(e.row, "hold_count", 32'(hold_count), 32'(e.hc));
        if (e.known) begin
          check(e.row, "IDEX_RegisterRs", 32'(IDEX_RegisterRs), 32'(e.rs));
          check(e.row, "IDEX_RegisterRt", 32'(IDEX_RegisterRt), 32'(e.rt));
          check(e.row, "IDEX_RegisterRd", 32'(IDEX_RegisterRd), 32'(e.rd));
          check(e.row, "IDEX_ReadData1", IDEX_ReadData1, e.d1);
          check(e.row, "IDEX_ReadData2", IDEX_ReadData2, e.d2);
          check(e.row, "IDEX_Imm", IDEX_Imm, e.imm);
        end
      end
    end

    // Hand sequence: hold straight after reset, then flush alone leaves counters alone
    @(negedge clk);
    reset = 1'b1; hold = 1'b0; flush = 1'b0; IFID_Valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; hold = 1'b1; IFID_Valid = 1'b1; IFID_Ctrl = LW;
    #1;
    check(100, "PCWrite_hold", 32'(PCWrite), 32'd0);
    check(100, "load_use_stall_idle", 32'(load_use_stall), 32'd0);
    @(negedge clk);
    hold = 1'b0; flush = 1'b1;
    #1;
    check(101, "PCWrite_flush", 32'(PCWrite), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    check(102, "hold_count_after_one", 32'(hold_count), 32'd1);
    check(102, "stall_count_after_flush", 32'(stall_count), 32'd0);
    check(102, "IDEX_Valid_after_flush", 32'(IDEX_Valid), 32'd0);
    check(102, "IDEX_Ctrl_after_flush", 32'(IDEX_Ctrl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
